// File: rtl/tipi_pkg.sv
// tipi_pkg: shared constants for the TIPI mailbox.
// Register offsets, window geometry and the window-base helper.
package tipi_pkg;

    typedef enum logic [2:0] {
        OFF_RC = 3'd1,
        OFF_RD = 3'd3,
        OFF_TC = 3'd5,
        OFF_TD = 3'd7
    } reg_off_e;

    localparam logic [15:0] WIN_SIZE = 16'd8;
    localparam logic [15:0] TOP_ADDR = 16'h6000;

    function automatic logic [15:0] win_base(input int nreg);
        return TOP_ADDR - 16'(nreg) * WIN_SIZE;
    endfunction

endpackage

// File: rtl/tipi_sync.sv
// tipi_sync: multi-flop synchroniser with a rising-edge pulse.
// One extra flop past the chain provides the edge history.
module tipi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o
);

    logic [STAGES:0] sr_q;

    // shift the asynchronous level through the chain
    always_ff @(posedge clk) begin
        if (reset) sr_q <= '0;
        else       sr_q <= {sr_q[STAGES-1:0], async_i};
    end

    assign sync_o = sr_q[STAGES-1];
    assign rise_o = sr_q[STAGES-1] & ~sr_q[STAGES];

endmodule

// File: rtl/tipi_mailbox.sv
// tipi_mailbox: TI-99 <-> RPi byte mailbox, NREG channels.
// Optional IRQ flags are built when TIPI_MAILBOX_IRQ_EN is defined.
module tipi_mailbox
    import tipi_pkg::*;
#(
    parameter int NREG        = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ti_a,
    input  logic        ti_memen,
    input  logic        ti_we,
    input  logic        ti_dbin,
    input  logic [7:0]  ti_d_in,
    output logic [7:0]  ti_d_out,
    output logic        ti_d_oe,
    input  logic        dev_en,
    input  logic        r_clk,
    input  logic        r_le,
    input  logic        r_dout,
    input  logic        r_rt,
    input  logic        r_cd,
    input  logic [2:0]  r_sel,
    output logic        r_din,
    output logic        ti_extint_n
);

    localparam logic [15:0] BASE = win_base(NREG);

    logic       rclk_s, rclk_rise;
    logic       rle_s, rle_rise;
    logic       rdout_s, rdout_rise;
    logic       memen_s, memen_rise;
    logic       we_s, we_rise;

    tipi_sync #(.STAGES(SYNC_STAGES)) u_sync_rclk (
        .clk(clk), .reset(reset), .async_i(r_clk),
        .sync_o(rclk_s), .rise_o(rclk_rise));
    tipi_sync #(.STAGES(SYNC_STAGES)) u_sync_rle (
        .clk(clk), .reset(reset), .async_i(r_le),
        .sync_o(rle_s), .rise_o(rle_rise));
    tipi_sync #(.STAGES(SYNC_STAGES)) u_sync_rdout (
        .clk(clk), .reset(reset), .async_i(r_dout),
        .sync_o(rdout_s), .rise_o(rdout_rise));
    tipi_sync #(.STAGES(SYNC_STAGES)) u_sync_memen (
        .clk(clk), .reset(reset), .async_i(ti_memen),
        .sync_o(memen_s), .rise_o(memen_rise));
    tipi_sync #(.STAGES(SYNC_STAGES)) u_sync_we (
        .clk(clk), .reset(reset), .async_i(ti_we),
        .sync_o(we_s), .rise_o(we_rise));

    logic unused_sync;
    assign unused_sync = ^{rclk_s, rle_s, rdout_rise,
                           memen_rise, we_rise};

    // address decode against the channel windows
    logic       in_win;
    logic [5:0] offs;
    logic [2:0] ch;
    logic [2:0] off;

    assign in_win = (ti_a >= BASE) && (ti_a < TOP_ADDR);
    assign offs   = 6'(ti_a - BASE);
    assign ch     = offs[5:3];
    assign off    = offs[2:0];

    assign ti_d_oe = dev_en & ~ti_memen & ti_dbin & in_win;

    // TI write strobe: fires on the 2nd cycle of a synced write
    logic       wr_act, wr_fire, wr_hit;
    logic [1:0] wr_q;

    assign wr_act  = ~memen_s & ~we_s;
    assign wr_fire = wr_act & wr_q[0] & ~wr_q[1];
    assign wr_hit  = wr_fire & dev_en & in_win &
                     ((off == OFF_TC) || (off == OFF_TD));

    // serial side qualifiers; le takes priority over a clk edge
    logic sel_ok, shift_in, shift_out, le_commit, le_load;

    assign sel_ok    = int'(r_sel) < NREG;
    assign shift_in  = rclk_rise & ~rle_rise & ~r_rt & sel_ok;
    assign shift_out = rclk_rise & ~rle_rise &  r_rt & sel_ok;
    assign le_commit = rle_rise & ~r_rt & sel_ok;
    assign le_load   = rle_rise &  r_rt & sel_ok;

    logic [7:0] rc_q [NREG];
    logic [7:0] rd_q [NREG];
    logic [7:0] tc_q [NREG];
    logic [7:0] td_q [NREG];
    logic [7:0] shrc_q [NREG];
    logic [7:0] shrd_q [NREG];
    logic [7:0] rc_d [NREG];
    logic [7:0] rd_d [NREG];
    logic [7:0] tc_d [NREG];
    logic [7:0] td_d [NREG];
    logic [7:0] shrc_d [NREG];
    logic [7:0] shrd_d [NREG];
    logic [7:0] out_q, out_d;
    logic       cm_q, cm_cd_q;
    logic [2:0] cm_sel_q;
    logic       din_q;

    // next-state for registers, shadows and the out-shifter
    always_comb begin
        rc_d   = rc_q;
        rd_d   = rd_q;
        tc_d   = tc_q;
        td_d   = td_q;
        shrc_d = shrc_q;
        shrd_d = shrd_q;
        out_d  = out_q;
        for (int k = 0; k < NREG; k++) begin
            if (shift_in && r_sel == 3'(k)) begin
                if (r_cd) shrd_d[k] = {shrd_q[k][6:0], rdout_s};
                else      shrc_d[k] = {shrc_q[k][6:0], rdout_s};
            end
            if (cm_q && cm_sel_q == 3'(k)) begin
                if (cm_cd_q) rd_d[k] = shrd_q[k];
                else         rc_d[k] = shrc_q[k];
            end
            if (wr_hit && ch == 3'(k)) begin
                if (off == OFF_TD) td_d[k] = ti_d_in;
                else               tc_d[k] = ti_d_in;
            end
            if (le_load && r_sel == 3'(k)) begin
                out_d = r_cd ? td_q[k] : tc_q[k];
            end
        end
        if (shift_out) out_d = {out_q[6:0], 1'b0};
    end

    // mailbox state update
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NREG; k++) begin
                rc_q[k]   <= '0;
                rd_q[k]   <= '0;
                tc_q[k]   <= '0;
                td_q[k]   <= '0;
                shrc_q[k] <= '0;
                shrd_q[k] <= '0;
            end
            out_q    <= '0;
            wr_q     <= '0;
            cm_q     <= 1'b0;
            cm_cd_q  <= 1'b0;
            cm_sel_q <= '0;
            din_q    <= 1'b0;
        end else begin
            rc_q     <= rc_d;
            rd_q     <= rd_d;
            tc_q     <= tc_d;
            td_q     <= td_d;
            shrc_q   <= shrc_d;
            shrd_q   <= shrd_d;
            out_q    <= out_d;
            wr_q     <= {wr_q[0], wr_act};
            cm_q     <= le_commit;
            cm_cd_q  <= r_cd;
            cm_sel_q <= r_sel;
            din_q    <= sel_ok & out_q[7];
        end
    end

    assign r_din = din_q;

    // read mux for the addressed register
    always_comb begin
        ti_d_out = 8'h00;
        for (int k = 0; k < NREG; k++) begin
            if (in_win && ch == 3'(k)) begin
                case (off)
                    OFF_RC:  ti_d_out = rc_q[k];
                    OFF_RD:  ti_d_out = rd_q[k];
                    OFF_TC:  ti_d_out = tc_q[k];
                    OFF_TD:  ti_d_out = td_q[k];
                    default: ti_d_out = 8'h00;
                endcase
            end
        end
    end

`ifdef TIPI_MAILBOX_IRQ_EN
    logic            rd_act, rd_q1, rd_first;
    logic [NREG-1:0] irq_q, irq_d;
    logic            extint_q;

    assign rd_act   = ~memen_s & ti_dbin;
    assign rd_first = rd_act & ~rd_q1;

    // IRQ flags: set on RC commit, cleared by RC read, set wins
    always_comb begin
        irq_d = irq_q;
        for (int k = 0; k < NREG; k++) begin
            if (rd_first && in_win && off == OFF_RC &&
                ch == 3'(k)) irq_d[k] = 1'b0;
            if (cm_q && !cm_cd_q && cm_sel_q == 3'(k))
                irq_d[k] = 1'b1;
        end
    end

    // IRQ flag and interrupt output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q1    <= 1'b0;
            irq_q    <= '0;
            extint_q <= 1'b1;
        end else begin
            rd_q1    <= rd_act;
            irq_q    <= irq_d;
            extint_q <= ~(dev_en & |irq_q);
        end
    end

    assign ti_extint_n = extint_q;
`else
    assign ti_extint_n = 1'b1;
`endif

endmodule

// File: tb/tb_tipi_mailbox.sv
// tb_tipi_mailbox: scoreboard bench for tipi_mailbox (NREG=2).
// Covers TI/RPi transfers, select range, reset, IRQ and races.
module tb_tipi_mailbox;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ti_a;
    logic        ti_memen, ti_we, ti_dbin;
    logic [7:0]  ti_d_in;
    logic [7:0]  ti_d_out;
    logic        ti_d_oe;
    logic        dev_en;
    logic        r_clk, r_le, r_dout, r_rt, r_cd;
    logic [2:0]  r_sel;
    logic        r_din;
    logic        ti_extint_n;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] sb_q [$];

    tipi_mailbox #(.NREG(2), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset),
        .ti_a(ti_a), .ti_memen(ti_memen), .ti_we(ti_we),
        .ti_dbin(ti_dbin), .ti_d_in(ti_d_in),
        .ti_d_out(ti_d_out), .ti_d_oe(ti_d_oe),
        .dev_en(dev_en),
        .r_clk(r_clk), .r_le(r_le), .r_dout(r_dout),
        .r_rt(r_rt), .r_cd(r_cd), .r_sel(r_sel),
        .r_din(r_din), .ti_extint_n(ti_extint_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_pop(input string tag, input logic [7:0] got);
        if (sb_q.size() == 0) chk({tag, "_sb_empty"}, 8'h01, 8'h00);
        else                  chk(tag, got, sb_q.pop_front());
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clk();
        r_clk = 1'b1; tick(4);
        r_clk = 1'b0; tick(4);
    endtask

    task automatic pulse_le();
        r_le = 1'b1; tick(4);
        r_le = 1'b0; tick(4);
    endtask

    task automatic shift_in(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            r_dout = b[i];
            tick(1);
            pulse_clk();
        end
        r_dout = 1'b0;
    endtask

    task automatic rpi_write(input logic [2:0] sel, input logic cd,
                             input logic [7:0] b);
        r_rt = 1'b0; r_sel = sel; r_cd = cd;
        tick(2);
        shift_in(b);
        pulse_le();
        tick(2);
    endtask

    task automatic shift_out(input string tag, input logic [7:0] b);
        for (int i = 7; i >= 0; i--) sb_q.push_back({7'd0, b[i]});
        for (int i = 0; i < 8; i++) begin
            sb_pop(tag, {7'd0, r_din});
            pulse_clk();
        end
    endtask

    task automatic rpi_read(input string tag, input logic [2:0] sel,
                            input logic cd, input logic [7:0] b);
        r_rt = 1'b1; r_sel = sel; r_cd = cd;
        tick(2);
        pulse_le();
        shift_out(tag, b);
    endtask

    task automatic ti_write(input logic [15:0] a, input logic [7:0] d);
        ti_a = a; ti_d_in = d;
        ti_memen = 1'b0; ti_we = 1'b0;
        tick(6);
        ti_memen = 1'b1; ti_we = 1'b1;
        tick(4);
    endtask

    task automatic ti_read(input string tag, input logic [15:0] a,
                           input logic [7:0] d, input logic oe);
        sb_q.push_back(d);
        ti_a = a; ti_memen = 1'b0; ti_dbin = 1'b1;
        tick(4);
        sb_pop(tag, ti_d_out);
        chk({tag, "_oe"}, {7'd0, ti_d_oe}, {7'd0, oe});
        ti_memen = 1'b1; ti_dbin = 1'b0;
        tick(3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        ti_a = 16'h0000; ti_memen = 1'b1; ti_we = 1'b1;
        ti_dbin = 1'b0; ti_d_in = 8'h00; dev_en = 1'b1;
        r_clk = 1'b0; r_le = 1'b0; r_dout = 1'b0;
        r_rt = 1'b0; r_cd = 1'b0; r_sel = 3'd0;
        tick(4);
        chk("rst_din", {7'd0, r_din}, 8'h00);
        chk("rst_int", {7'd0, ti_extint_n}, 8'h01);
        chk("rst_oe", {7'd0, ti_d_oe}, 8'h00);
        reset = 1'b0;
        tick(2);
        ti_read("rst_rc0", 16'h5FF1, 8'h00, 1'b1);
        ti_read("rst_td1", 16'h5FFF, 8'h00, 1'b1);

        // TI write to ch1 TD, RPi reads it out MSB-first
        ti_write(16'h5FFF, 8'hA5);
        rpi_read("tiwr", 3'd1, 1'b1, 8'hA5);
        ti_read("td1", 16'h5FFF, 8'hA5, 1'b1);

        // RPi write to ch0 RC; RD untouched
        rpi_write(3'd0, 1'b0, 8'h3C);
        ti_read("rc0", 16'h5FF1, 8'h3C, 1'b1);
        ti_read("rd0", 16'h5FF3, 8'h00, 1'b1);
        ti_read("even", 16'h5FF0, 8'h00, 1'b1);
        ti_read("unmap", 16'h6001, 8'h00, 1'b0);
        ti_write(16'h5FF1, 8'h77);
        ti_read("rc_ro", 16'h5FF1, 8'h3C, 1'b1);
        dev_en = 1'b0;
        ti_read("devoff", 16'h5FF1, 8'h3C, 1'b0);
        dev_en = 1'b1;

        // out-of-range select: din forced low, no writes
        r_rt = 1'b1; r_sel = 3'd1; r_cd = 1'b1;
        tick(2);
        pulse_le();
        sb_q.push_back(8'h01);
        sb_pop("oor_pre", {7'd0, r_din});
        r_sel = 3'd2;
        tick(3);
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back(8'h00);
            sb_pop("oor_din", {7'd0, r_din});
            pulse_clk();
        end
        rpi_write(3'd2, 1'b0, 8'hFF);
        rpi_write(3'd2, 1'b1, 8'hFF);
        ti_read("oor_rc0", 16'h5FF1, 8'h3C, 1'b1);
        ti_read("oor_rd0", 16'h5FF3, 8'h00, 1'b1);
        ti_read("oor_rc1", 16'h5FF9, 8'h00, 1'b1);
        ti_read("oor_rd1", 16'h5FFB, 8'h00, 1'b1);

        // reset in the middle of a transfer
        r_rt = 1'b0; r_sel = 3'd0; r_cd = 1'b1;
        tick(2);
        for (int i = 0; i < 4; i++) begin
            r_dout = i[0];
            tick(1);
            pulse_clk();
        end
        reset = 1'b1;
        tick(3);
        chk("mrst_din", {7'd0, r_din}, 8'h00);
        chk("mrst_int", {7'd0, ti_extint_n}, 8'h01);
        reset = 1'b0;
        tick(2);
        ti_read("mrst_rc0", 16'h5FF1, 8'h00, 1'b1);
        ti_read("mrst_td1", 16'h5FFF, 8'h00, 1'b1);
        rpi_write(3'd0, 1'b1, 8'hFF);
        ti_read("mrst_rd0", 16'h5FF3, 8'hFF, 1'b1);

        // RC commit on ch1 raises (or not) the interrupt
        r_rt = 1'b0; r_sel = 3'd1; r_cd = 1'b0;
        tick(2);
        shift_in(8'h5A);
        r_le = 1'b1;
        n = 0;
`ifdef TIPI_MAILBOX_IRQ_EN
        while (ti_extint_n !== 1'b0 && n < 5) begin
            tick(1);
            n++;
        end
        chk("irq_set", {7'd0, ti_extint_n}, 8'h00);
`else
        tick(5);
        chk("irq_off", {7'd0, ti_extint_n}, 8'h01);
`endif
        r_le = 1'b0;
        tick(4);
        ti_read("irq_rc1", 16'h5FF9, 8'h5A, 1'b1);
        tick(3);
        chk("irq_clr", {7'd0, ti_extint_n}, 8'h01);

        // TI write to TC racing a shifter load of TC
        ti_write(16'h5FF5, 8'h80);
        r_rt = 1'b1; r_sel = 3'd0; r_cd = 1'b0;
        tick(3);
        ti_a = 16'h5FF5; ti_d_in = 8'h11;
        ti_memen = 1'b0; ti_we = 1'b0;
        tick(1);
        r_le = 1'b1;
        tick(5);
        ti_memen = 1'b1; ti_we = 1'b1; r_le = 1'b0;
        tick(4);
        shift_out("race_old", 8'h80);
        rpi_read("race_new", 3'd0, 1'b0, 8'h11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
